// File: rtl/alu_reservation_station_pkg.sv
// rtl/alu_reservation_station_pkg.sv - shared widths, defaults and internal opcode encoding
package alu_reservation_station_pkg;

    localparam int RS_SIZE_DEF   = 8;
    localparam int ROB_IDX_W_DEF = 6;
    localparam int OPCODE_W      = 6;
    localparam int XLEN          = 32;

    typedef logic [OPCODE_W-1:0] opcode_t;
    typedef logic [XLEN-1:0]     word_t;

    // Opcode 0 on the ALU port means the ALU is idle this cycle
    localparam opcode_t OP_NOP  = 6'd0;
    localparam opcode_t OP_ADD  = 6'd1;
    localparam opcode_t OP_SUB  = 6'd2;
    localparam opcode_t OP_AND  = 6'd3;
    localparam opcode_t OP_OR   = 6'd4;
    localparam opcode_t OP_XOR  = 6'd5;
    localparam opcode_t OP_ADDI = 6'd11;
    localparam opcode_t OP_LUI  = 6'd16;
    localparam opcode_t OP_BEQ  = 6'd21;
    localparam opcode_t OP_BNE  = 6'd22;
    localparam opcode_t OP_JAL  = 6'd30;
    localparam opcode_t OP_JALR = 6'd31;

endpackage

// File: rtl/alu_reservation_station_rs_select.sv
// rtl/alu_reservation_station_rs_select.sv - combinational issue picker and free-slot finder
// Macro RS_AGE_ORDER_EN: issue pick uses the age matrix (oldest ready first).
module alu_reservation_station_rs_select #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]          cand_i,
    input  logic [N-1:0]          free_i,
`ifdef RS_AGE_ORDER_EN
    input  logic [N-1:0][N-1:0]   age_i,
`endif
    output logic [IDX_W-1:0]      issue_idx_o,
    output logic                  issue_vld_o,
    output logic [IDX_W-1:0]      free_idx_o,
    output logic                  free_vld_o
);

    logic [N-1:0] pick;

`ifdef RS_AGE_ORDER_EN
    // age_i[k][c] set means entry k is older than entry c; drop c if an older candidate exists
    always_comb begin
        pick = cand_i;
        for (int c = 0; c < N; c++) begin
            for (int k = 0; k < N; k++) begin
                if (cand_i[k] && age_i[k][c]) begin
                    pick[c] = 1'b0;
                end
            end
        end
    end
`else
    assign pick = cand_i;
`endif

    always_comb begin
        issue_idx_o = '0;
        issue_vld_o = 1'b0;
        free_idx_o  = '0;
        free_vld_o  = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pick[i]) begin
                issue_idx_o = IDX_W'(i);
                issue_vld_o = 1'b1;
            end
            if (free_i[i]) begin
                free_idx_o = IDX_W'(i);
                free_vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_reservation_station.sv
// rtl/alu_reservation_station.sv - ALU reservation station: dispatch, CDB wakeup, select and issue
// Macro RS_AGE_ORDER_EN: keep an age matrix and issue the oldest ready entry.
module alu_reservation_station
    import alu_reservation_station_pkg::*;
#(
    parameter int RS_SIZE   = RS_SIZE_DEF,
    parameter int ROB_IDX_W = ROB_IDX_W_DEF
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear,
    input  logic                 disp_valid,
    input  logic [5:0]           disp_opcode,
    input  logic                 disp_rdy1,
    input  logic                 disp_rdy2,
    input  logic [31:0]          disp_val1,
    input  logic [31:0]          disp_val2,
    input  logic [ROB_IDX_W-1:0] disp_q1,
    input  logic [ROB_IDX_W-1:0] disp_q2,
    input  logic [31:0]          disp_imm,
    input  logic [31:0]          disp_pc,
    input  logic [ROB_IDX_W-1:0] disp_rob_index,
    output logic                 full,
    input  logic                 alu_cdb_valid,
    input  logic [ROB_IDX_W-1:0] alu_cdb_rob_index,
    input  logic [31:0]          alu_cdb_res,
    input  logic                 lsb_cdb_valid,
    input  logic [ROB_IDX_W-1:0] lsb_cdb_rob_index,
    input  logic [31:0]          lsb_cdb_res,
    output logic [5:0]           alu_opcode,
    output logic [31:0]          alu_val1,
    output logic [31:0]          alu_val2,
    output logic [31:0]          alu_imm,
    output logic [31:0]          alu_pc,
    output logic [ROB_IDX_W-1:0] alu_rob_index
);

    localparam int IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0]   busy_q, busy_d, rdy1_q, rdy1_d, rdy2_q, rdy2_d;
    opcode_t              op_q   [RS_SIZE];
    opcode_t              op_d   [RS_SIZE];
    word_t                val1_q [RS_SIZE];
    word_t                val1_d [RS_SIZE];
    word_t                val2_q [RS_SIZE];
    word_t                val2_d [RS_SIZE];
    word_t                imm_q  [RS_SIZE];
    word_t                imm_d  [RS_SIZE];
    word_t                pc_q   [RS_SIZE];
    word_t                pc_d   [RS_SIZE];
    logic [ROB_IDX_W-1:0] q1_q   [RS_SIZE];
    logic [ROB_IDX_W-1:0] q1_d   [RS_SIZE];
    logic [ROB_IDX_W-1:0] q2_q   [RS_SIZE];
    logic [ROB_IDX_W-1:0] q2_d   [RS_SIZE];
    logic [ROB_IDX_W-1:0] rob_q  [RS_SIZE];
    logic [ROB_IDX_W-1:0] rob_d  [RS_SIZE];

    opcode_t              alu_opcode_q, alu_opcode_d;
    word_t                alu_val1_q, alu_val1_d, alu_val2_q, alu_val2_d;
    word_t                alu_imm_q, alu_imm_d, alu_pc_q, alu_pc_d;
    logic [ROB_IDX_W-1:0] alu_rob_q, alu_rob_d;

    logic [RS_SIZE-1:0] cand;
    logic [IDX_W-1:0]   issue_idx, free_idx;
    logic               issue_vld, free_vld, disp_fire;
    logic               b1_alu, b1_lsb, b2_alu, b2_lsb;

    assign cand      = busy_q & rdy1_q & rdy2_q;
    assign full      = &busy_q;
    assign disp_fire = rdy_in && disp_valid && free_vld;

    assign b1_alu = alu_cdb_valid && (disp_q1 == alu_cdb_rob_index);
    assign b1_lsb = lsb_cdb_valid && (disp_q1 == lsb_cdb_rob_index);
    assign b2_alu = alu_cdb_valid && (disp_q2 == alu_cdb_rob_index);
    assign b2_lsb = lsb_cdb_valid && (disp_q2 == lsb_cdb_rob_index);

`ifdef RS_AGE_ORDER_EN
    logic [RS_SIZE-1:0][RS_SIZE-1:0] age_q, age_d;

    // New entry is younger than every entry already waiting
    always_comb begin
        age_d = age_q;
        if (disp_fire) begin
            age_d[free_idx] = '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy_q[i]) begin
                    age_d[i][free_idx] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || clear) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end
`endif

    alu_reservation_station_rs_select #(
        .N     (RS_SIZE),
        .IDX_W (IDX_W)
    ) u_select (
        .cand_i      (cand),
        .free_i      (~busy_q),
`ifdef RS_AGE_ORDER_EN
        .age_i       (age_q),
`endif
        .issue_idx_o (issue_idx),
        .issue_vld_o (issue_vld),
        .free_idx_o  (free_idx),
        .free_vld_o  (free_vld)
    );

    always_comb begin
        busy_d = busy_q;
        rdy1_d = rdy1_q;
        rdy2_d = rdy2_q;
        op_d   = op_q;
        val1_d = val1_q;
        val2_d = val2_q;
        imm_d  = imm_q;
        pc_d   = pc_q;
        q1_d   = q1_q;
        q2_d   = q2_q;
        rob_d  = rob_q;
        alu_opcode_d = alu_opcode_q;
        alu_val1_d   = alu_val1_q;
        alu_val2_d   = alu_val2_q;
        alu_imm_d    = alu_imm_q;
        alu_pc_d     = alu_pc_q;
        alu_rob_d    = alu_rob_q;

        if (rdy_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy_q[i] && !rdy1_q[i]) begin
                    if (alu_cdb_valid && q1_q[i] == alu_cdb_rob_index) begin
                        rdy1_d[i] = 1'b1;
                        val1_d[i] = alu_cdb_res;
                    end else if (lsb_cdb_valid && q1_q[i] == lsb_cdb_rob_index) begin
                        rdy1_d[i] = 1'b1;
                        val1_d[i] = lsb_cdb_res;
                    end
                end
                if (busy_q[i] && !rdy2_q[i]) begin
                    if (alu_cdb_valid && q2_q[i] == alu_cdb_rob_index) begin
                        rdy2_d[i] = 1'b1;
                        val2_d[i] = alu_cdb_res;
                    end else if (lsb_cdb_valid && q2_q[i] == lsb_cdb_rob_index) begin
                        rdy2_d[i] = 1'b1;
                        val2_d[i] = lsb_cdb_res;
                    end
                end
            end

            alu_opcode_d = OP_NOP;
            if (issue_vld) begin
                busy_d[issue_idx] = 1'b0;
                alu_opcode_d      = op_q[issue_idx];
                alu_val1_d        = val1_q[issue_idx];
                alu_val2_d        = val2_q[issue_idx];
                alu_imm_d         = imm_q[issue_idx];
                alu_pc_d          = pc_q[issue_idx];
                alu_rob_d         = rob_q[issue_idx];
            end

            // The free slot is never the issuing slot, so wakeup/issue cannot collide with it
            if (disp_fire) begin
                busy_d[free_idx] = 1'b1;
                op_d[free_idx]   = disp_opcode;
                imm_d[free_idx]  = disp_imm;
                pc_d[free_idx]   = disp_pc;
                rob_d[free_idx]  = disp_rob_index;
                q1_d[free_idx]   = disp_q1;
                q2_d[free_idx]   = disp_q2;
                rdy1_d[free_idx] = disp_rdy1 || b1_alu || b1_lsb;
                rdy2_d[free_idx] = disp_rdy2 || b2_alu || b2_lsb;
                val1_d[free_idx] = disp_rdy1 ? disp_val1 :
                                   b1_alu    ? alu_cdb_res :
                                   b1_lsb    ? lsb_cdb_res : disp_val1;
                val2_d[free_idx] = disp_rdy2 ? disp_val2 :
                                   b2_alu    ? alu_cdb_res :
                                   b2_lsb    ? lsb_cdb_res : disp_val2;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || clear) begin
            busy_q       <= '0;
            alu_opcode_q <= OP_NOP;
            alu_val1_q   <= '0;
            alu_val2_q   <= '0;
            alu_imm_q    <= '0;
            alu_pc_q     <= '0;
            alu_rob_q    <= '0;
        end else begin
            busy_q       <= busy_d;
            alu_opcode_q <= alu_opcode_d;
            alu_val1_q   <= alu_val1_d;
            alu_val2_q   <= alu_val2_d;
            alu_imm_q    <= alu_imm_d;
            alu_pc_q     <= alu_pc_d;
            alu_rob_q    <= alu_rob_d;
        end
    end

    // Payload is qualified by busy_q, so it needs no reset
    always_ff @(posedge clk_in) begin
        rdy1_q <= rdy1_d;
        rdy2_q <= rdy2_d;
        op_q   <= op_d;
        val1_q <= val1_d;
        val2_q <= val2_d;
        imm_q  <= imm_d;
        pc_q   <= pc_d;
        q1_q   <= q1_d;
        q2_q   <= q2_d;
        rob_q  <= rob_d;
    end

    assign alu_opcode    = alu_opcode_q;
    assign alu_val1      = alu_val1_q;
    assign alu_val2      = alu_val2_q;
    assign alu_imm       = alu_imm_q;
    assign alu_pc        = alu_pc_q;
    assign alu_rob_index = alu_rob_q;

endmodule

// File: tb/tb_alu_reservation_station.sv
// tb/tb_alu_reservation_station.sv - scoreboard bench for alu_reservation_station (RS_SIZE=8, ROB_IDX_W=6)
module tb_alu_reservation_station;
    import alu_reservation_station_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear;
    logic        disp_valid, disp_rdy1, disp_rdy2;
    logic [5:0]  disp_opcode, disp_q1, disp_q2, disp_rob_index;
    logic [31:0] disp_val1, disp_val2, disp_imm, disp_pc;
    logic        full;
    logic        alu_cdb_valid, lsb_cdb_valid;
    logic [5:0]  alu_cdb_rob_index, lsb_cdb_rob_index;
    logic [31:0] alu_cdb_res, lsb_cdb_res;
    logic [5:0]  alu_opcode, alu_rob_index;
    logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [5:0]  rob;
    } exp_t;

    exp_t sb[$];
    exp_t mon_act, mon_exp;
    int   checks = 0;
    int   errors = 0;

    always #5 clk_in = ~clk_in;

    alu_reservation_station #(.RS_SIZE(8), .ROB_IDX_W(6)) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .rdy_in            (rdy_in),
        .clear             (clear),
        .disp_valid        (disp_valid),
        .disp_opcode       (disp_opcode),
        .disp_rdy1         (disp_rdy1),
        .disp_rdy2         (disp_rdy2),
        .disp_val1         (disp_val1),
        .disp_val2         (disp_val2),
        .disp_q1           (disp_q1),
        .disp_q2           (disp_q2),
        .disp_imm          (disp_imm),
        .disp_pc           (disp_pc),
        .disp_rob_index    (disp_rob_index),
        .full              (full),
        .alu_cdb_valid     (alu_cdb_valid),
        .alu_cdb_rob_index (alu_cdb_rob_index),
        .alu_cdb_res       (alu_cdb_res),
        .lsb_cdb_valid     (lsb_cdb_valid),
        .lsb_cdb_rob_index (lsb_cdb_rob_index),
        .lsb_cdb_res       (lsb_cdb_res),
        .alu_opcode        (alu_opcode),
        .alu_val1          (alu_val1),
        .alu_val2          (alu_val2),
        .alu_imm           (alu_imm),
        .alu_pc            (alu_pc),
        .alu_rob_index     (alu_rob_index)
    );

    // Monitor: every non-stalled cycle with a live opcode consumes one expected issue
    always @(negedge clk_in) begin
        if (!rst_in && rdy_in && alu_opcode != OP_NOP) begin
            mon_act = '{alu_opcode, alu_val1, alu_val2, alu_imm, alu_pc, alu_rob_index};
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_issue actual op=%0d rob=%0d v1=%h required=no issue",
                         alu_opcode, alu_rob_index, alu_val1);
            end else begin
                mon_exp = sb.pop_front();
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("FAIL issue actual op=%0d v1=%h v2=%h imm=%h pc=%h rob=%0d required op=%0d v1=%h v2=%h imm=%h pc=%h rob=%0d",
                             mon_act.op, mon_act.v1, mon_act.v2, mon_act.imm, mon_act.pc, mon_act.rob,
                             mon_exp.op, mon_exp.v1, mon_exp.v2, mon_exp.imm, mon_exp.pc, mon_exp.rob);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic expect_issue(input logic [5:0] op, input logic [31:0] v1, input logic [31:0] v2,
                                input logic [31:0] imm, input logic [31:0] pc, input logic [5:0] rob);
        exp_t e;
        e = '{op, v1, v2, imm, pc, rob};
        sb.push_back(e);
    endtask

    task automatic dispatch(input logic [5:0] op, input logic r1, input logic [31:0] v1, input logic [5:0] t1,
                            input logic r2, input logic [31:0] v2, input logic [5:0] t2,
                            input logic [31:0] imm, input logic [31:0] pc, input logic [5:0] rob);
        chk("not_full_at_dispatch", {31'd0, full}, 32'd0);
        disp_valid = 1'b1; disp_opcode = op;
        disp_rdy1 = r1; disp_val1 = v1; disp_q1 = t1;
        disp_rdy2 = r2; disp_val2 = v2; disp_q2 = t2;
        disp_imm = imm; disp_pc = pc; disp_rob_index = rob;
        tick();
        disp_valid = 1'b0;
    endtask

    task automatic alu_bcast(input logic [5:0] tag, input logic [31:0] res);
        alu_cdb_valid = 1'b1; alu_cdb_rob_index = tag; alu_cdb_res = res;
        tick();
        alu_cdb_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) tick();
        chk("scoreboard_drained", sb.size(), 32'd0);
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0;
        disp_valid = 1'b0; disp_opcode = '0; disp_rdy1 = 1'b0; disp_rdy2 = 1'b0;
        disp_val1 = '0; disp_val2 = '0; disp_q1 = '0; disp_q2 = '0;
        disp_imm = '0; disp_pc = '0; disp_rob_index = '0;
        alu_cdb_valid = 1'b0; alu_cdb_rob_index = '0; alu_cdb_res = '0;
        lsb_cdb_valid = 1'b0; lsb_cdb_rob_index = '0; lsb_cdb_res = '0;
        tick(); tick();
        rst_in = 1'b0;
        chk("reset_full", {31'd0, full}, 32'd0);
        chk("reset_opcode", {26'd0, alu_opcode}, 32'd0);
        chk("reset_val1", alu_val1, 32'd0);
        chk("reset_rob", {26'd0, alu_rob_index}, 32'd0);

        // ADDI with operands ready: visible two cycles after dispatch, for one cycle
        expect_issue(OP_ADDI, 32'd5, 32'd0, 32'd3, 32'h100, 6'd2);
        dispatch(OP_ADDI, 1'b1, 32'd5, 6'd0, 1'b1, 32'd0, 6'd0, 32'd3, 32'h100, 6'd2);
        chk("addi_not_early", {26'd0, alu_opcode}, 32'd0);
        tick();
        chk("addi_opcode", {26'd0, alu_opcode}, {26'd0, OP_ADDI});
        chk("addi_val1", alu_val1, 32'd5);
        chk("addi_imm", alu_imm, 32'd3);
        chk("addi_rob", {26'd0, alu_rob_index}, 32'd2);
        tick();
        chk("addi_one_cycle", {26'd0, alu_opcode}, 32'd0);

        // ADD waiting on tag 7, woken by the ALU CDB
        expect_issue(OP_ADD, 32'h20, 32'd10, 32'd0, 32'h104, 6'd3);
        dispatch(OP_ADD, 1'b0, 32'd0, 6'd7, 1'b1, 32'd10, 6'd0, 32'd0, 32'h104, 6'd3);
        tick();
        chk("add_waits", {26'd0, alu_opcode}, 32'd0);
        alu_bcast(6'd7, 32'h20);
        chk("add_wake_latency", {26'd0, alu_opcode}, 32'd0);
        tick();
        chk("add_issue", {26'd0, alu_opcode}, {26'd0, OP_ADD});
        chk("add_val1", alu_val1, 32'h20);
        tick();

        // BEQ captures its operand from the LSB CDB in the dispatch cycle
        expect_issue(OP_BEQ, 32'd1, 32'd9, 32'h10, 32'h108, 6'd5);
        lsb_cdb_valid = 1'b1; lsb_cdb_rob_index = 6'd4; lsb_cdb_res = 32'd9;
        dispatch(OP_BEQ, 1'b1, 32'd1, 6'd0, 1'b0, 32'd0, 6'd4, 32'h10, 32'h108, 6'd5);
        lsb_cdb_valid = 1'b0;
        tick();
        chk("beq_issue", {26'd0, alu_opcode}, {26'd0, OP_BEQ});
        chk("beq_val2", alu_val2, 32'd9);
        tick();

        // Fill every entry behind tag 1, then release them all at once
        for (int i = 0; i < 8; i++) begin
            expect_issue(OP_ADD, 32'h77, 32'(i), 32'd0, 32'h200 + 32'(4 * i), 6'(8 + i));
            dispatch(OP_ADD, 1'b0, 32'd0, 6'd1, 1'b1, 32'(i), 6'd0, 32'd0, 32'h200 + 32'(4 * i), 6'(8 + i));
        end
        chk("fill_full", {31'd0, full}, 32'd1);
        alu_bcast(6'd1, 32'h77);
        tick();
        for (int k = 0; k < 8; k++) begin
            chk("fill_consecutive", {26'd0, alu_opcode}, {26'd0, OP_ADD});
            tick();
        end
        chk("fill_done_idle", {26'd0, alu_opcode}, 32'd0);
        chk("fill_done_not_full", {31'd0, full}, 32'd0);

        // Flush with two waiting entries and one about to issue
        dispatch(OP_SUB, 1'b0, 32'd0, 6'd9, 1'b1, 32'd1, 6'd0, 32'd0, 32'h300, 6'd30);
        dispatch(OP_SUB, 1'b0, 32'd0, 6'd9, 1'b1, 32'd2, 6'd0, 32'd0, 32'h304, 6'd31);
        dispatch(OP_SUB, 1'b1, 32'd3, 6'd0, 1'b1, 32'd4, 6'd0, 32'd0, 32'h308, 6'd32);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear_full", {31'd0, full}, 32'd0);
        chk("clear_opcode", {26'd0, alu_opcode}, 32'd0);
        chk("clear_val1", alu_val1, 32'd0);
        alu_bcast(6'd9, 32'h99);
        for (int i = 0; i < 4; i++) tick();

        // Stall: a ready entry must not issue and a CDB must not wake anything
        expect_issue(OP_ADD, 32'd3, 32'd4, 32'd0, 32'h400, 6'd20);
        expect_issue(OP_XOR, 32'h66, 32'd6, 32'd0, 32'h404, 6'd21);
        dispatch(OP_XOR, 1'b0, 32'd0, 6'd11, 1'b1, 32'd6, 6'd0, 32'd0, 32'h404, 6'd21);
        dispatch(OP_ADD, 1'b1, 32'd3, 6'd0, 1'b1, 32'd4, 6'd0, 32'd0, 32'h400, 6'd20);
        rdy_in = 1'b0;
        alu_cdb_valid = 1'b1; alu_cdb_rob_index = 6'd11; alu_cdb_res = 32'h55;
        for (int i = 0; i < 3; i++) begin
            chk("stall_no_issue", {26'd0, alu_opcode}, 32'd0);
            chk("stall_frozen_rob", {26'd0, alu_rob_index}, 32'd0);
            tick();
        end
        alu_cdb_valid = 1'b0;
        rdy_in = 1'b1;
        chk("stall_release_idle", {26'd0, alu_opcode}, 32'd0);
        alu_bcast(6'd11, 32'h66);
        chk("resume_issue", {26'd0, alu_opcode}, {26'd0, OP_ADD});
        chk("resume_rob", {26'd0, alu_rob_index}, 32'd20);
        drain(20);
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Reservation station feeding the single combinational ALU in the out-of-order core.
- Accepts decoded ALU/branch/jump ops from the dispatcher and holds them until both operands are present.
- Captures operand values broadcast on the ALU and LSB CDBs.
- Issues at most one ready op per cycle into registered ALU input ports; `opcode == 0` means an idle ALU.

Parameters:
- RS_SIZE, 8, number of entries (power of two, 2..16).
- ROB_IDX_W, 6, width of ROB index / dependency tag.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  global ready; low = hold all state
- clear  input  1  ROB misprediction flush
- disp_valid  input  1  dispatch request
- disp_opcode  input  6  internal opcode (const.v encoding, nonzero)
- disp_rdy1 / disp_rdy2  input  1 each  operand value present
- disp_val1 / disp_val2  input  32 each  operand values
- disp_q1 / disp_q2  input  ROB_IDX_W each  producer tag when not ready
- disp_imm  input  32  immediate
- disp_pc  input  32  instruction pc
- disp_rob_index  input  ROB_IDX_W  destination ROB entry
- full  output  1  no free entry
- alu_cdb_valid, alu_cdb_rob_index, alu_cdb_res  input  1/ROB_IDX_W/32  ALU broadcast
- lsb_cdb_valid, lsb_cdb_rob_index, lsb_cdb_res  input  1/ROB_IDX_W/32  LSB broadcast
- alu_opcode  output  6  issued op, 0 = none
- alu_val1, alu_val2, alu_imm, alu_pc  output  32 each  issued operands
- alu_rob_index  output  ROB_IDX_W  issued destination

Behaviour:
- Priority: rst_in > clear > !rdy_in > normal. Reset and clear act regardless of rdy_in.
- Reset/clear: all busy bits and age state cleared; alu_opcode = 0; all alu_* outputs = 0; full = 0.
- !rdy_in: entries, outputs and age state hold; dispatch and CDB inputs are ignored.
- full: combinational; high iff all RS_SIZE entries are busy. Dispatch while full is illegal; the bench asserts on it. Dispatch goes into the lowest-index free entry.
- Dispatch/CDB bypass: if an operand is not ready but its tag matches a valid CDB in the same cycle, the entry is written ready with the CDB value. LSB and ALU tags are never equal in one cycle.
- Wakeup: every busy, non-ready operand whose tag matches a valid CDB captures the value and sets ready at the clock edge.
- Select and issue:
  - Uses registered state only. Candidate = busy and both operands ready.
  - Default policy picks the lowest-index candidate.
  - The chosen entry is freed at the edge, and its fields load into the alu_* registers.
  - With no candidate, alu_opcode <= 0 and the other alu_* outputs hold.
- An entry freed by issue is reusable by dispatch on the next edge; same-edge reuse is not allowed.
- Latency:
  - Dispatch at cycle t with both operands ready → written at edge t → alu_opcode valid during cycle t+2.
  - CDB broadcast at cycle t wakes an entry → earliest alu_opcode valid during cycle t+2.
- Back-to-back dependency: the ALU result of cycle t arrives on alu_cdb at cycle t and wakes its consumer, which issues the next cycle. Minimum dependent spacing is 2 cycles.
- Each issued op appears on alu_opcode for exactly one non-stalled cycle.

Optional Feature:
- Macro: RS_AGE_ORDER_EN.
- Defined: an RS_SIZE×RS_SIZE age matrix is kept. On dispatch, the new row is cleared and the new column is set in every other busy row. Select picks the oldest candidate (the candidate whose row has no older candidate set).
- Undefined: lowest-index select, no age storage.
- All other behaviour is identical.

Decomposition:
- const.v: opcode defines (existing), RS_SIZE default, ROB_IDX_W, NOP opcode 0.
- One sub-module, rs_select: combinational picker taking candidate and free vectors.
  - Outputs: issue index + valid, free index + valid.
  - Contains the age-matrix compare under RS_AGE_ORDER_EN.

Test Plan:
- Reset, then dispatch ADDI (rdy1=1, val1=5, imm=3, rob=2) at cycle 1 → alu_opcode=ADDI, alu_val1=5, alu_imm=3, alu_rob_index=2 in cycle 3; alu_opcode=0 in cycle 4.
- Dispatch ADD with rdy1=0, q1=7, val2=10; alu_cdb (rob 7, res 0x20) two cycles later → issue next cycle with alu_val1=0x20, alu_val2=10.
- Dispatch BEQ with q2=4 in the same cycle lsb_cdb broadcasts rob 4, res 9 → entry captured ready; issue two cycles later with alu_val2=9.
- Fill 8 entries, all waiting on tag 1 → full=1. Broadcast tag 1 → eight consecutive issues. Issue order is entry 0..7, or dispatch order under RS_AGE_ORDER_EN with scrambled free slots.
- Pulse clear with 3 busy entries and a pending issue → next cycle full=0, alu_opcode=0, and no stale issue follows.
- Hold rdy_in=0 for 3 cycles with a ready entry and a CDB broadcast → no issue, no wakeup, outputs frozen; resumes after rdy_in=1.
